dpll_decide_ctrl: RTL and testbench

- Decision/backtrack controller that drives the BCP unit: owns the assignment/free vectors, issues bcp_request, and consumes the BCP result (done, conflict, implied literals).
- Performs chronological DPLL: lowest-index-free-variable decisions, implication merge, flip-on-conflict backtracking.
- Reports sat/unsat to the top-level solver controller.

---
 rtl/dpll_decide_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dpll_decide_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dpll_decide_ctrl.sv
// Chronological DPLL decision/backtrack controller driving an external BCP unit.
// Define BCP_WATCHDOG_EN to add a watchdog that abandons a BCP request after TIMEOUT_CYCLES.
module dpll_decide_ctrl #(
  parameter int VAR_NUM        = 4,
  parameter int VAR_NUM_LOG    = 2,
  parameter int DEFAULT_POL    = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               bcp_request,
  input  logic               bcp_done,
  input  logic               bcp_conflict,
  input  logic [VAR_NUM-1:0] imp_mask,
  input  logic [VAR_NUM-1:0] imp_value,
  output logic [VAR_NUM-1:0] assignment,
  output logic [VAR_NUM-1:0] free,
  output logic               busy,
  output logic               sat,
  output logic               unsat,
  output logic               bcp_timeout
);

  localparam int   LVL_W   = VAR_NUM_LOG + 1;
  localparam logic DEF_POL = 1'(DEFAULT_POL);

  if (((1 << VAR_NUM_LOG) < VAR_NUM) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("dpll_decide_ctrl: VAR_NUM_LOG too small or TIMEOUT_CYCLES < 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DECIDE, S_BACKTRACK, S_SAT, S_UNSAT
  } state_t;

  state_t state, state_nxt;

  logic [LVL_W-1:0]                       level;
  // Trail slot 0 is never used; decisions live in slots 1..VAR_NUM.
  logic [VAR_NUM:0][VAR_NUM_LOG-1:0]      trail_var;
  logic [VAR_NUM:0]                       trail_flip;
  logic [VAR_NUM-1:0][LVL_W-1:0]          var_level;

  logic [LVL_W-1:0]       level_inc;
  logic [VAR_NUM_LOG-1:0] dec_var;
  logic [VAR_NUM_LOG-1:0] bt_var;
  logic                   bt_flipped;

  function automatic logic [VAR_NUM_LOG-1:0] lowest_set(input logic [VAR_NUM-1:0] vec);
    lowest_set = '0;
    for (int i = VAR_NUM - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = VAR_NUM_LOG'(i);
    end
  endfunction

  assign level_inc  = level + LVL_W'(1);
  assign dec_var    = lowest_set(free);
  assign bt_var     = trail_var[level];
  assign bt_flipped = trail_flip[level];

  assign bcp_request = (state == S_REQ);
  assign sat         = (state == S_SAT);
  assign unsat       = (state == S_UNSAT);
  assign busy        = !((state == S_IDLE) || (state == S_SAT) || (state == S_UNSAT));

`ifdef BCP_WATCHDOG_EN
  localparam int                 WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic            timeout_q;

  // bcp_done in the limit cycle takes precedence over the watchdog.
  assign wd_fire     = (state == S_WAIT) && !bcp_done && (wd_cnt == WD_LAST);
  assign bcp_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_REQ) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !bcp_done && !wd_fire) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end else if (start && !busy) begin
        timeout_q <= 1'b0;
      end
    end
  end
`else
  logic wd_fire;
  assign wd_fire     = 1'b0;
  assign bcp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_SAT, S_UNSAT: if (start) state_nxt = S_REQ;
      S_REQ:                  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bcp_done) begin
          if (bcp_conflict) state_nxt = (level == '0) ? S_UNSAT : S_BACKTRACK;
          else              state_nxt = S_DECIDE;
        end else if (wd_fire) begin
          state_nxt = S_IDLE;
        end
      end
      S_DECIDE:               state_nxt = (free == '0) ? S_SAT : S_REQ;
      S_BACKTRACK: begin
        if (!bt_flipped)                state_nxt = S_REQ;
        else if (level == LVL_W'(1))    state_nxt = S_UNSAT;
      end
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assignment <= '0;
      free       <= '1;
      level      <= '0;
      trail_var  <= '0;
      trail_flip <= '0;
      var_level  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_SAT, S_UNSAT: begin
          if (start) begin
            assignment <= '0;
            free       <= '1;
            level      <= '0;
          end
        end
        S_WAIT: begin
          // Merge implications only into still-free variables.
          if (bcp_done && !bcp_conflict) begin
            for (int i = 0; i < VAR_NUM; i++) begin
              if (imp_mask[i] && free[i]) begin
                free[i]       <= 1'b0;
                assignment[i] <= imp_value[i];
                var_level[i]  <= level;
              end
            end
          end
        end
        S_DECIDE: begin
          if (free != '0) begin
            level                 <= level_inc;
            trail_var[level_inc]  <= dec_var;
            trail_flip[level_inc] <= 1'b0;
            assignment[dec_var]   <= DEF_POL;
            free[dec_var]         <= 1'b0;
            var_level[dec_var]    <= level_inc;
          end
        end
        S_BACKTRACK: begin
          for (int i = 0; i < VAR_NUM; i++) begin
            if ((var_level[i] == level) && !free[i]) begin
              free[i]       <= 1'b1;
              assignment[i] <= 1'b0;
            end
          end
          // The flip is written after the clear so it wins for the decided variable.
          if (!bt_flipped) begin
            assignment[bt_var] <= ~assignment[bt_var];
            free[bt_var]       <= 1'b0;
            trail_flip[level]  <= 1'b1;
          end else begin
            level <= level - LVL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpll_decide_ctrl.sv
// Table-driven bench for dpll_decide_ctrl: each record is one BCP response and the event it must lead to.
module tb_dpll_decide_ctrl;

  localparam int EV_REQ   = 0;
  localparam int EV_SAT   = 1;
  localparam int EV_UNSAT = 2;

  logic       clk = 1'b0;
  logic       rst, start, bcp_done, bcp_conflict;
  logic [3:0] imp_mask, imp_value;
  logic       bcp_request, busy, sat, unsat, bcp_timeout;
  logic [3:0] assignment, free;

  always #5 clk = ~clk;

  dpll_decide_ctrl #(
    .VAR_NUM(4), .VAR_NUM_LOG(2), .DEFAULT_POL(0), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bcp_request(bcp_request),
    .bcp_done(bcp_done), .bcp_conflict(bcp_conflict),
    .imp_mask(imp_mask), .imp_value(imp_value),
    .assignment(assignment), .free(free), .busy(busy),
    .sat(sat), .unsat(unsat), .bcp_timeout(bcp_timeout)
  );

  int checks   = 0;
  int failures = 0;
  int req_count = 0;
  int base_req  = 0;

  always @(negedge clk) if (bcp_request) req_count++;

  typedef struct {
    bit         new_scen;
    bit         conflict;
    logic [3:0] mask;
    logic [3:0] value;
    int         exp_ev;
    int         exp_lat;
    logic [3:0] exp_free;
    logic [3:0] exp_asg;
    int         exp_reqs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit ns, bit cf, logic [3:0] m, logic [3:0] v, int ev, int lat,
                              logic [3:0] f, logic [3:0] a, int reqs);
    vec_t r;
    r.new_scen = ns; r.conflict = cf; r.mask = m; r.value = v;
    r.exp_ev = ev; r.exp_lat = lat; r.exp_free = f; r.exp_asg = a; r.exp_reqs = reqs;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after start was sampled.
  task automatic do_start();
    base_req = req_count;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_req_next_cycle", bcp_request, 1'b1);
    check("start_free", free, 4'b1111);
    check("start_asg", assignment, 4'b0000);
    check("start_flags", {sat, unsat, busy}, 3'b001);
  endtask

  // Called at the negedge of a REQ cycle; bcp_done is presented during the WAIT cycle.
  task automatic respond(input bit cf, input logic [3:0] m, input logic [3:0] v);
    @(posedge clk); #1;
    bcp_done = 1'b1; bcp_conflict = cf; imp_mask = m; imp_value = v;
    @(posedge clk); #1;
    bcp_done = 1'b0; bcp_conflict = 1'b0; imp_mask = '0; imp_value = '0;
  endtask

  task automatic wait_event(output int ev, output int lat);
    bit got;
    got = 1'b0; ev = -1; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!got) begin
        @(negedge clk);
        if (bcp_request)  begin ev = EV_REQ;   lat = c; got = 1'b1; end
        else if (sat)     begin ev = EV_SAT;   lat = c; got = 1'b1; end
        else if (unsat)   begin ev = EV_UNSAT; lat = c; got = 1'b1; end
      end
    end
  endtask

  initial begin
    int ev, lat;
    rst = 1'b1; start = 1'b0; bcp_done = 1'b0; bcp_conflict = 1'b0;
    imp_mask = '0; imp_value = '0;

    // Scenario A: all propagations clean, four decisions then SAT.
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1110, 4'b0000, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1100, 4'b0000, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1000, 4'b0000, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b0000, 4'b0000, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_SAT,   2, 4'b0000, 4'b0000,  5));
    // Scenario B: conflict at level 0.
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, EV_UNSAT, 1, 4'b1111, 4'b0000,  1));
    // Scenario C: flip var0, decide var1, flip var1, then unwind two levels.
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1110, 4'b0000, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1110, 4'b0001, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1100, 4'b0001, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1100, 4'b0011, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_UNSAT, 3, 4'b1111, 4'b0000,  5));
    // Scenario D: level-0 implications survive exhaustion of var0.
    vecs.push_back(mk(1, 0, 4'b0110, 4'b0100, EV_REQ,   2, 4'b1000, 4'b0100, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1000, 4'b0101, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_UNSAT, 2, 4'b1001, 4'b0100,  3));
    // Scenario E: level-1 implications (one on an assigned var), unwind to level 1, then SAT.
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1110, 4'b0000, -1));
    vecs.push_back(mk(0, 0, 4'b1011, 4'b1111, EV_REQ,   2, 4'b0000, 4'b1010, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_REQ,   2, 4'b0000, 4'b1110, -1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, EV_REQ,   3, 4'b1110, 4'b0001, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1100, 4'b0001, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b1000, 4'b0001, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_REQ,   2, 4'b0000, 4'b0001, -1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, EV_SAT,   2, 4'b0000, 4'b0001,  8));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_free", free, 4'b1111);
    check("reset_asg", assignment, 4'b0000);
    check("reset_req", bcp_request, 1'b0);
    check("reset_flags", {busy, sat, unsat, bcp_timeout}, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].new_scen) do_start();
      respond(vecs[i].conflict, vecs[i].mask, vecs[i].value);
      wait_event(ev, lat);
      check($sformatf("v%0d_event", i), ev, vecs[i].exp_ev);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_free", i), free, vecs[i].exp_free);
      check($sformatf("v%0d_asg", i), assignment, vecs[i].exp_asg);
      check($sformatf("v%0d_busy", i), busy, (vecs[i].exp_ev == EV_REQ));
      if (vecs[i].exp_reqs >= 0)
        check($sformatf("v%0d_req_count", i), req_count - base_req, vecs[i].exp_reqs);
    end

    // SAT is held and ignores stray BCP responses.
    bcp_done = 1'b1; bcp_conflict = 1'b1; imp_mask = 4'b1111; imp_value = 4'b1111;
    repeat (3) @(negedge clk);
    bcp_done = 1'b0; bcp_conflict = 1'b0; imp_mask = '0; imp_value = '0;
    check("sat_hold_flags", {sat, unsat, busy, bcp_request}, 4'b1000);
    check("sat_hold_free", free, 4'b0000);
    check("sat_hold_asg", assignment, 4'b0001);

    // start is ignored while busy; rst overrides an outstanding response.
    do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_ignored_req", bcp_request, 1'b0);
    check("start_ignored_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; bcp_done = 1'b1; imp_mask = 4'b1111; imp_value = 4'b1111;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_free", free, 4'b1111);
    check("midrst_asg", assignment, 4'b0000);
    check("midrst_flags", {busy, sat, unsat, bcp_request}, 4'b0000);
    @(posedge clk); #1;
    bcp_done = 1'b0; imp_mask = '0; imp_value = '0;
    @(negedge clk);
    check("midrst_idle_free", free, 4'b1111);
    check("midrst_idle_busy", busy, 1'b0);

`ifdef BCP_WATCHDOG_EN
    begin
      int  n;
      bit  got;
      do_start();
      n = 0; got = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (!got && bcp_timeout) begin got = 1'b1; n = c; end
      end
      check("wd_timeout_seen", got, 1'b1);
      check("wd_timeout_cycle", n, 9);
      check("wd_idle_flags", {busy, sat, unsat, bcp_request}, 4'b0000);
      do_start();
      check("wd_cleared_by_start", bcp_timeout, 1'b0);
    end
`else
    check("no_wd_timeout", bcp_timeout, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
